sparse_chunk_packer: RTL and testbench

SPARSE_CHUNK_PACKER -- requirements
Module: sparse_chunk_packer

---
 rtl/sparse_chunk_packer.sv | 224 ++++++++++++++++++++++
 tb/tb_sparse_chunk_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_chunk_packer.sv
// Packs dense channel beats into fixed-size chunks of sparse map plus compacted
// nonzero values, then streams each chunk out as WR_CYC SRAM write beats.
module sparse_chunk_packer #(
  parameter  int unsigned BUS_SIZE   = 8,
  parameter  int unsigned DAT_SIZE   = 8,
  parameter  int unsigned CHUNK_SIZE = 32,
  parameter  int unsigned CHUNK_NUM  = 64,
  localparam int unsigned WR_CYC     = CHUNK_SIZE / BUS_SIZE,
  localparam int unsigned DCW        = (WR_CYC > 1) ? $clog2(WR_CYC) : 1,
  localparam int unsigned CCW        = $clog2(CHUNK_NUM)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [15:0]                  cfg_chan_num_i,
  input  logic [15:0]                  cfg_pos_num_i,
  input  logic                         cfg_dense_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [BUS_SIZE*DAT_SIZE-1:0] in_data_i,
  output logic                         wr_valid_o,
  input  logic                         wr_ready_i,
  output logic [BUS_SIZE-1:0]          wr_sparsemap_o,
  output logic [BUS_SIZE*DAT_SIZE-1:0] wr_nonzero_data_o,
  output logic [DCW-1:0]               wr_dat_count_o,
  output logic [CCW-1:0]               wr_chunk_count_o,
  output logic                         finish_o,
  output logic                         overflow_o
);

  localparam int unsigned JW = $clog2(CHUNK_SIZE + 1);

  typedef enum logic [2:0] {IDLE, FILL, PAD, EMIT, DONE} state_e;

  state_e                         state_q;
  logic [15:0]                    pos_q, z_num_q, rem_q, z_q, p_q;
  logic                           dense_q;
  logic [DCW-1:0]                 last_idx_q, beat_q;
  logic [JW-1:0]                  j_q, j_d;
  logic [CHUNK_SIZE-1:0]          smap_q, smap_d;
  logic [CHUNK_SIZE*DAT_SIZE-1:0] data_q, data_d;
  logic                           wr_valid_q, finish_q, overflow_q;
  logic [BUS_SIZE-1:0]            wr_smap_q;
  logic [BUS_SIZE*DAT_SIZE-1:0]   wr_data_q;
  logic [DCW-1:0]                 wr_dat_count_q;
  logic [CCW-1:0]                 chunk_q;

  logic                           last_z, last_chunk, fire_in, fire_wr;
  logic [DCW-1:0]                 fill_last_idx;
  int unsigned                    start_zn, start_rem, start_lidx;
  int unsigned                    jt, lane_idx, emit_nxt;
  logic [DAT_SIZE-1:0]            lane_v;
  logic                           lane_pad;

  assign in_ready_o        = (state_q == FILL);
  assign wr_valid_o        = wr_valid_q;
  assign wr_sparsemap_o    = wr_smap_q;
  assign wr_nonzero_data_o = wr_data_q;
  assign wr_dat_count_o    = wr_dat_count_q;
  assign wr_chunk_count_o  = chunk_q;
  assign finish_o          = finish_q;
  assign overflow_o        = overflow_q;

  assign last_z        = (z_q == z_num_q - 16'd1);
  assign last_chunk    = last_z && (p_q == pos_q - 16'd1);
  assign fill_last_idx = last_z ? last_idx_q : DCW'(WR_CYC - 1);
  assign fire_in       = (state_q == FILL) && in_valid_i;
  assign fire_wr       = wr_valid_q && wr_ready_i;
  assign emit_nxt      = 32'(wr_dat_count_q) + 1;

  // Chunk geometry derived from the raw config at start time.
  always_comb begin
    start_zn   = (32'(cfg_chan_num_i) + CHUNK_SIZE - 1) / CHUNK_SIZE;
    start_rem  = (start_zn == 0) ? 0 : 32'(cfg_chan_num_i) - (start_zn - 1) * CHUNK_SIZE;
    start_lidx = (start_rem == 0) ? 0 : (start_rem + BUS_SIZE - 1) / BUS_SIZE - 1;
  end

  // One consumed beat: lanes past the channel count are zeroed, then either
  // stored in place (dense) or appended at the compaction pointer.
  always_comb begin
    smap_d   = smap_q;
    data_d   = data_q;
    jt       = 32'(j_q);
    lane_idx = 0;
    lane_v   = '0;
    lane_pad = 1'b0;
    if (fire_in) begin
      for (int unsigned l = 0; l < BUS_SIZE; l++) begin
        lane_idx = 32'(beat_q) * BUS_SIZE + l;
        lane_pad = last_z && (lane_idx >= 32'(rem_q));
        lane_v   = lane_pad ? '0 : in_data_i[l*DAT_SIZE +: DAT_SIZE];
        if (dense_q) begin
          smap_d[lane_idx]                      = !lane_pad;
          data_d[lane_idx*DAT_SIZE +: DAT_SIZE] = lane_v;
        end else if (lane_v != '0) begin
          smap_d[lane_idx]                = 1'b1;
          data_d[jt*DAT_SIZE +: DAT_SIZE] = lane_v;
          jt++;
        end
      end
    end
    j_d = JW'(jt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      pos_q          <= '0;
      z_num_q        <= '0;
      rem_q          <= '0;
      z_q            <= '0;
      p_q            <= '0;
      dense_q        <= 1'b0;
      last_idx_q     <= '0;
      beat_q         <= '0;
      j_q            <= '0;
      smap_q         <= '0;
      data_q         <= '0;
      wr_valid_q     <= 1'b0;
      wr_smap_q      <= '0;
      wr_data_q      <= '0;
      wr_dat_count_q <= '0;
      chunk_q        <= '0;
      finish_q       <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            pos_q      <= cfg_pos_num_i;
            dense_q    <= cfg_dense_i;
            z_num_q    <= 16'(start_zn);
            rem_q      <= 16'(start_rem);
            last_idx_q <= DCW'(start_lidx);
            z_q        <= '0;
            p_q        <= '0;
            beat_q     <= '0;
            j_q        <= '0;
            smap_q     <= '0;
            data_q     <= '0;
            chunk_q    <= '0;
            overflow_q <= 1'b0;
            if (cfg_chan_num_i != 16'd0 && cfg_pos_num_i != 16'd0) begin
              state_q <= FILL;
            end else begin
              state_q  <= DONE;
              finish_q <= 1'b1;
            end
          end
        end
        FILL: begin
          smap_q <= smap_d;
          data_q <= data_d;
          j_q    <= j_d;
          if (fire_in) begin
            if (beat_q == fill_last_idx && fill_last_idx == DCW'(WR_CYC - 1)) begin
              state_q        <= EMIT;
              beat_q         <= '0;
              wr_valid_q     <= 1'b1;
              wr_smap_q      <= smap_d[BUS_SIZE-1:0];
              wr_data_q      <= data_d[BUS_SIZE*DAT_SIZE-1:0];
              wr_dat_count_q <= '0;
            end else begin
              if (beat_q == fill_last_idx) state_q <= PAD;
              beat_q <= beat_q + DCW'(1);
            end
          end
        end
        PAD: begin
          // The buffer is already cleared, so padding only advances the beat slot.
          if (beat_q == DCW'(WR_CYC - 1)) begin
            state_q        <= EMIT;
            beat_q         <= '0;
            wr_valid_q     <= 1'b1;
            wr_smap_q      <= smap_q[BUS_SIZE-1:0];
            wr_data_q      <= data_q[BUS_SIZE*DAT_SIZE-1:0];
            wr_dat_count_q <= '0;
          end else begin
            beat_q <= beat_q + DCW'(1);
          end
        end
        EMIT: begin
          if (fire_wr) begin
            if (wr_dat_count_q == DCW'(WR_CYC - 1)) begin
              wr_valid_q     <= 1'b0;
              wr_smap_q      <= '0;
              wr_data_q      <= '0;
              wr_dat_count_q <= '0;
              smap_q         <= '0;
              data_q         <= '0;
              j_q            <= '0;
              if (chunk_q == CCW'(CHUNK_NUM - 1)) begin
                chunk_q    <= '0;
                overflow_q <= 1'b1;
              end else begin
                chunk_q <= chunk_q + CCW'(1);
              end
              if (last_chunk) begin
                state_q  <= DONE;
                finish_q <= 1'b1;
              end else begin
                state_q <= FILL;
                if (p_q == pos_q - 16'd1) begin
                  p_q <= '0;
                  z_q <= z_q + 16'd1;
                end else begin
                  p_q <= p_q + 16'd1;
                end
              end
            end else begin
              wr_dat_count_q <= wr_dat_count_q + DCW'(1);
              wr_smap_q      <= smap_q[emit_nxt*BUS_SIZE +: BUS_SIZE];
              wr_data_q      <= data_q[emit_nxt*BUS_SIZE*DAT_SIZE +: BUS_SIZE*DAT_SIZE];
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_chunk_packer.sv
// Directed bench for sparse_chunk_packer: BUS_SIZE=8, DAT_SIZE=8, CHUNK_SIZE=32, CHUNK_NUM=64.
module tb_sparse_chunk_packer;

  logic        clk = 1'b0;
  logic        rst, start, dense, in_valid, in_ready, wr_valid, wr_ready, finish, ovf;
  logic [15:0] chan, pos;
  logic [63:0] in_data, wdata;
  logic [7:0]  smap;
  logic [1:0]  dcnt;
  logic [5:0]  ccnt;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  sparse_chunk_packer #(
    .BUS_SIZE(8), .DAT_SIZE(8), .CHUNK_SIZE(32), .CHUNK_NUM(64)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cfg_chan_num_i(chan), .cfg_pos_num_i(pos), .cfg_dense_i(dense),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
    .wr_sparsemap_o(smap), .wr_nonzero_data_o(wdata),
    .wr_dat_count_o(dcnt), .wr_chunk_count_o(ccnt),
    .finish_o(finish), .overflow_o(ovf)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] seq_beat(int unsigned base);
    logic [63:0] r;
    for (int unsigned l = 0; l < 8; l++) r[l*8 +: 8] = 8'(base + l);
    return r;
  endfunction

  // odd channels carry their own index, even channels are zero
  function automatic logic [63:0] odd_beat(int unsigned b);
    logic [63:0] r;
    for (int unsigned l = 0; l < 8; l++) r[l*8 +: 8] = (l % 2 == 1) ? 8'(8*b + l) : 8'h00;
    return r;
  endfunction

  // compacted view of the odd-channel chunk: 1,3,5,...,31 then zeros
  function automatic logic [63:0] odd_comp(int unsigned k);
    logic [63:0] r;
    for (int unsigned l = 0; l < 8; l++) r[l*8 +: 8] = (k < 2) ? 8'(16*k + 2*l + 1) : 8'h00;
    return r;
  endfunction

  task automatic do_start(input logic [15:0] c, input logic [15:0] p, input logic d);
    chan = c; pos = p; dense = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int unsigned n = 0;
    in_data = d; in_valid = 1'b1;
    while (!in_ready && n < 20) begin step(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got=0 exp=1");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!wr_valid && n < 20) begin step(); n++; end
    if (!wr_valid) begin
      checks++; errors++;
      $display("FAIL wr_valid_timeout got=0 exp=1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++;
    if ({smap, wdata, dcnt, ccnt, finish, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got smap=%h data=%h dcnt=%0d ccnt=%0d fin=%b ovf=%b exp all 0",
               smap, wdata, dcnt, ccnt, finish, ovf);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_chunk();
    int unsigned n;
    do_start(16'd32, 16'd1, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready got=%b exp=1", in_ready); end
    for (int unsigned b = 0; b < 4; b++) send_beat(seq_beat(8*b + 1));
    for (int unsigned k = 0; k < 4; k++) begin
      wait_valid(n);
      checks++; if (smap !== 8'hFF) begin errors++; $display("FAIL full_smap beat%0d got=%h exp=ff", k, smap); end
      checks++; if (wdata !== seq_beat(8*k + 1)) begin errors++; $display("FAIL full_data beat%0d got=%h exp=%h", k, wdata, seq_beat(8*k + 1)); end
      checks++; if (dcnt !== 2'(k)) begin errors++; $display("FAIL full_dcnt got=%0d exp=%0d", dcnt, k); end
      checks++; if (ccnt !== 6'd0) begin errors++; $display("FAIL full_ccnt got=%0d exp=0", ccnt); end
      step();
    end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL full_finish got=%b exp=1", finish); end
    step();
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL full_finish_pulse got=%b exp=0", finish); end
  endtask

  task automatic test_sparse();
    int unsigned n;
    do_start(16'd32, 16'd1, 1'b0);
    for (int unsigned b = 0; b < 4; b++) send_beat(odd_beat(b));
    for (int unsigned k = 0; k < 4; k++) begin
      wait_valid(n);
      checks++; if (smap !== 8'hAA) begin errors++; $display("FAIL sparse_smap beat%0d got=%h exp=aa", k, smap); end
      checks++; if (wdata !== odd_comp(k)) begin errors++; $display("FAIL sparse_data beat%0d got=%h exp=%h", k, wdata, odd_comp(k)); end
      step();
    end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL sparse_finish got=%b exp=1", finish); end
    step();
  endtask

  task automatic test_pad();
    int unsigned n;
    logic [7:0]  es;
    logic [63:0] ed;
    do_start(16'd36, 16'd2, 1'b0);
    for (int unsigned ch = 0; ch < 4; ch++) begin
      for (int unsigned b = 0; b < ((ch < 2) ? 4 : 1); b++) send_beat('1);
      wait_valid(n);
      checks++;
      if (n != ((ch < 2) ? 0 : 3)) begin errors++; $display("FAIL pad_latency chunk%0d got=%0d exp=%0d", ch, n, (ch < 2) ? 0 : 3); end
      for (int unsigned k = 0; k < 4; k++) begin
        if (k > 0) wait_valid(n);
        es = (ch < 2) ? 8'hFF : ((k == 0) ? 8'h0F : 8'h00);
        ed = (ch < 2) ? '1 : ((k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'h0);
        checks++; if (smap !== es) begin errors++; $display("FAIL pad_smap c%0d b%0d got=%h exp=%h", ch, k, smap, es); end
        checks++; if (wdata !== ed) begin errors++; $display("FAIL pad_data c%0d b%0d got=%h exp=%h", ch, k, wdata, ed); end
        checks++; if (ccnt !== 6'(ch)) begin errors++; $display("FAIL pad_ccnt got=%0d exp=%0d", ccnt, ch); end
        step();
      end
    end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL pad_finish got=%b exp=1", finish); end
    step();
  endtask

  task automatic test_back_pressure();
    int unsigned n;
    do_start(16'd32, 16'd1, 1'b0);
    for (int unsigned b = 0; b < 4; b++) send_beat(seq_beat(8*b + 'h41));
    for (int unsigned k = 0; k < 4; k++) begin
      wait_valid(n);
      checks++; if (wdata !== seq_beat(8*k + 'h41) || dcnt !== 2'(k)) begin
        errors++; $display("FAIL stall_beat%0d got=%h/%0d exp=%h/%0d", k, wdata, dcnt, seq_beat(8*k + 'h41), k);
      end
      if (k == 1) begin
        wr_ready = 1'b0;
        for (int unsigned s = 0; s < 3; s++) begin
          step();
          checks++;
          if (wr_valid !== 1'b1 || smap !== 8'hFF || wdata !== seq_beat('h49) || dcnt !== 2'd1) begin
            errors++; $display("FAIL stall_hold cyc%0d got v=%b s=%h d=%h c=%0d exp v=1 s=ff d=%h c=1",
                               s, wr_valid, smap, wdata, dcnt, seq_beat('h49));
          end
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        end
        wr_ready = 1'b1;
      end
      step();
    end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL stall_finish got=%b exp=1", finish); end
    step();
  endtask

  task automatic test_wrap();
    int unsigned beats = 0;
    logic seen63 = 1'b0;
    logic ovf_at63 = 1'b0;
    do_start(16'd64, 16'd40, 1'b0);
    in_data = {8{8'h01}};
    in_valid = 1'b1;
    for (int i = 0; i < 3000 && !finish; i++) begin
      step();
      if (wr_valid) beats++;
      if (ccnt == 6'd63 && !seen63) begin seen63 = 1'b1; ovf_at63 = ovf; end
    end
    in_valid = 1'b0;
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL wrap_finish_timeout got=%b exp=1", finish); end
    checks++; if (beats != 320) begin errors++; $display("FAIL wrap_beats got=%0d exp=320", beats); end
    checks++; if (seen63 !== 1'b1 || ovf_at63 !== 1'b0) begin errors++; $display("FAIL wrap_pre got seen63=%b ovf=%b exp 1/0", seen63, ovf_at63); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_overflow got=%b exp=1", ovf); end
    checks++; if (ccnt !== 6'd16) begin errors++; $display("FAIL wrap_ccnt got=%0d exp=16", ccnt); end
    step();
    do_start(16'd0, 16'd0, 1'b0);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL restart_overflow got=%b exp=0", ovf); end
    checks++; if (ccnt !== 6'd0) begin errors++; $display("FAIL restart_ccnt got=%0d exp=0", ccnt); end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL empty_finish got=%b exp=1", finish); end
    step();
  endtask

  task automatic test_reset_mid_emit();
    int unsigned n;
    do_start(16'd32, 16'd1, 1'b0);
    for (int unsigned b = 0; b < 4; b++) send_beat(seq_beat(8*b + 1));
    wait_valid(n);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({wr_valid, smap, wdata, dcnt, ccnt, finish, ovf, in_ready} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b s=%h d=%h c=%0d cc=%0d f=%b o=%b r=%b exp all 0",
               wr_valid, smap, wdata, dcnt, ccnt, finish, ovf, in_ready);
    end
    step(); step();
    checks++; if (in_ready !== 1'b0 || wr_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle got r=%b v=%b exp 0/0", in_ready, wr_valid); end
    do_start(16'd32, 16'd1, 1'b1);
    for (int unsigned b = 0; b < 4; b++) send_beat(odd_beat(b));
    for (int unsigned k = 0; k < 4; k++) begin
      wait_valid(n);
      checks++; if (smap !== 8'hFF) begin errors++; $display("FAIL dense_smap beat%0d got=%h exp=ff", k, smap); end
      checks++; if (wdata !== odd_beat(k)) begin errors++; $display("FAIL dense_data beat%0d got=%h exp=%h", k, wdata, odd_beat(k)); end
      checks++; if (ccnt !== 6'd0) begin errors++; $display("FAIL dense_ccnt got=%0d exp=0", ccnt); end
      step();
    end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL dense_finish got=%b exp=1", finish); end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; chan = '0; pos = '0; dense = 1'b0;
    in_valid = 1'b0; in_data = '0; wr_ready = 1'b1;
    test_reset();
    test_full_chunk();
    test_sparse();
    test_pad();
    test_back_pressure();
    test_wrap();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
